ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Manual word-entry writer into data memory; counterpart of the RAM-to-7-seg display reader.
//  Operator enters a 32-bit word as hex nibbles from 4 switches, one per debounced key press.
//  Commit key issues a req/ack write of that word to a switch-selected address.
//  Sits beside CPU in top; drives the CPU data-memory debug write port.
// PARAMETERS
//  ADDR_W      7     word-address width (matches showaddr)
//  DATA_W      32    word width; multiple of 4
//  ACK_TIMEOUT 255   cycles in WRITE without wr_ack before abort with err
// PORTS
//  sysclk      in  1       system clock; all state on rising edge
//  reset       in  1       asynchronous, active-high
//  sw_nibble   in  4       hex digit to enter
//  sw_addr     in  ADDR_W  target word address
//  key_enter   in  1       debounced level; rising edge shifts in sw_nibble
//  key_commit  in  1       debounced level; rising edge starts write
//  key_clear   in  1       debounced level; rising edge clears entry and err
//  wr_req      out 1       write request; held until wr_ack
//  wr_addr     out ADDR_W  write address, stable while wr_req=1
//  wr_data     out DATA_W  write data, stable while wr_req=1
//  wr_ack      in  1       memory accepted write (sampled when wr_req=1)
//  entry_data  out DATA_W  word under construction (feeds display)
//  nib_cnt     out 4       nibbles entered, 0..DATA_W/4, saturating
//  busy        out 1       1 in WRITE
//  done        out 1       one-cycle pulse after accepted write
//  err         out 1       sticky: write timed out
// BEHAVIOUR
//  Reset: all outputs 0; state=ENTRY; timeout counter 0.
//  Keys: each passes a 2-FF synchronizer, then rising-edge detect (sync2 & ~prev).
//   Action registers on the 3rd sysclk edge after the key level rises. Held keys act once.
//  Priority, same cycle: clear > commit > enter; lower-priority edges are discarded.
//  ENTRY state:
//   enter: if nib_cnt<DATA_W/4, entry_data<={entry_data[DATA_W-5:0],sw_nibble}, nib_cnt++.
//    At nib_cnt==DATA_W/4, enter is ignored (no shift, no wrap).
//   clear: entry_data=0, nib_cnt=0, err=0.
//   commit with nib_cnt==0: ignored. With nib_cnt>0: wr_addr<=sw_addr, wr_data<=entry_data,
//    timeout cnt=0, go WRITE; wr_req=1 from the next cycle.
//  WRITE state: wr_req=1, busy=1; all key edges ignored; wr_addr/wr_data frozen.
//   wr_ack=1 sampled: go DONE; wr_req falls the following cycle.
//   Ack coinciding with the timeout expiry counts as success.
//   Else, after ACK_TIMEOUT cycles: err=1, wr_req=0, back to ENTRY, entry preserved.
//  DONE state (1 cycle): done=1, entry_data=0, nib_cnt=0, then ENTRY.
//  wr_ack while wr_req=0 is ignored.
//  Reset mid-WRITE: wr_req drops immediately (async); no write is retried.
//  States: ENTRY=2'd0, WRITE=2'd1, DONE=2'd2; 2'd3 recovers to ENTRY.
// STRUCTURE
//  ram_loader_defs.vh: state localparams, nibble-count width.
//  Sub-module edge_sync (2-FF sync + rising-edge pulse, async reset), instantiated 3x.
//  Top of ram_loader: FSM, entry shift register, timeout counter.
// TESTING
//  Enter 1,2,3,4,5,6,7,8; commit with sw_addr=7'h05; ack after 3 cycles ->
//   wr_data=32'h12345678, wr_addr=5, done pulses once, nib_cnt=0.
//  Enter 10 nibbles 0..9 -> entry_data=32'h01234567, nib_cnt=8; extra presses ignored.
//  Commit with nib_cnt=0 -> wr_req stays 0 and state stays ENTRY.
//  Enter A,B then commit, no ack -> wr_req high exactly ACK_TIMEOUT cycles,
//   then err=1 and entry_data=32'h000000AB; clear -> err=0, entry=0.
//  Clear+commit+enter same cycle -> only clear acts; key held 100 cycles -> one action.
//  Assert reset during WRITE -> wr_req=0 asynchronously, all outputs 0; ENTRY after release.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
// Shared types and constants for the manual RAM word loader.
//   state_t : loader FSM states (ENTRY, WRITE, DONE; the fourth encoding is
//             unused and falls back to ENTRY)
//   NIB_W   : width of the nibble counter exposed on nib_cnt
package ram_loader_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam int NIB_W = 4;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if
// Request/acknowledge write port between the loader and the data memory.
//   wr_req  : write request, held until wr_ack
//   wr_addr : word address, stable while wr_req is high
//   wr_data : word data, stable while wr_req is high
//   wr_ack  : memory accepted the write (only meaningful while wr_req is high)
// master = loader side, slave = memory side.
interface ram_loader_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;

   modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
   modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/edge_sync.sv
// edge_sync
// Brings an asynchronous, already-debounced key level into the sysclk domain
// and produces a one-cycle pulse on its rising edge.
//   sysclk : system clock
//   reset  : asynchronous active-high reset
//   din    : raw key level
//   pulse  : high for one cycle, the cycle after the synchronized level rises
// The pulse is combinational from the synchronizer flops, so a consumer that
// registers on it acts on the third clock edge after the key level rises.
module edge_sync (
   input  logic sysclk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic prev;

   // Two-flop synchronizer followed by a delayed copy for edge detection.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign pulse = sync2 & ~prev;

endmodule

// File: rtl/ram_loader.sv
// ram_loader
// Lets an operator type a word as hex nibbles on switches and commit it to
// data memory through a req/ack write port.
//   sysclk, reset : clock and asynchronous active-high reset
//   sw_nibble     : hex digit to shift in on an enter press
//   sw_addr       : target word address captured on commit
//   key_enter     : rising edge shifts sw_nibble into the entry word
//   key_commit    : rising edge starts a write of the entry word
//   key_clear     : rising edge clears the entry word and the error flag
//   wr            : memory write port (master side)
//   entry_data    : word under construction
//   nib_cnt       : nibbles entered so far, saturates at DATA_W/4
//   busy          : high while a write is outstanding
//   done          : one-cycle pulse after the memory accepts a write
//   err           : sticky flag, the memory never acknowledged a write
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [3:0]        sw_nibble,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic              key_enter,
   input  logic              key_commit,
   input  logic              key_clear,
   ram_loader_if.master      wr,
   output logic [DATA_W-1:0] entry_data,
   output logic [NIB_W-1:0]  nib_cnt,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [NIB_W-1:0] NIB_MAX  = NIB_W'(DATA_W / 4);

   logic              enter_p;
   logic              commit_p;
   logic              clear_p;
   state_t            state;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              wr_req_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   edge_sync u_sync_enter  (.sysclk(sysclk), .reset(reset), .din(key_enter),  .pulse(enter_p));
   edge_sync u_sync_commit (.sysclk(sysclk), .reset(reset), .din(key_commit), .pulse(commit_p));
   edge_sync u_sync_clear  (.sysclk(sysclk), .reset(reset), .din(key_clear),  .pulse(clear_p));

   assign wr.wr_req  = wr_req_q;
   assign wr.wr_addr = wr_addr_q;
   assign wr.wr_data = wr_data_q;

   // Loader FSM. Key pulses are only honoured in ENTRY, with clear beating
   // commit beating enter when several arrive together. In WRITE the timeout
   // counter tracks how many cycles the request has been waiting; an ack that
   // lands on the final allowed cycle is checked first and therefore wins.
   // done is set on the way into DONE so it is high for exactly the DONE cycle.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state      <= ST_ENTRY;
         tmo_cnt    <= '0;
         wr_req_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         entry_data <= '0;
         nib_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_ENTRY: begin
               if (clear_p) begin
                  entry_data <= '0;
                  nib_cnt    <= '0;
                  err        <= 1'b0;
               end else if (commit_p) begin
                  if (nib_cnt != '0) begin
                     wr_addr_q <= sw_addr;
                     wr_data_q <= entry_data;
                     tmo_cnt   <= '0;
                     wr_req_q  <= 1'b1;
                     busy      <= 1'b1;
                     state     <= ST_WRITE;
                  end
               end else if (enter_p) begin
                  if (nib_cnt < NIB_MAX) begin
                     entry_data <= {entry_data[DATA_W-5:0], sw_nibble};
                     nib_cnt    <= nib_cnt + 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (wr.wr_ack) begin
                  wr_req_q <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  wr_req_q <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  state    <= ST_ENTRY;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               entry_data <= '0;
               nib_cnt    <= '0;
               state      <= ST_ENTRY;
            end
            default: begin
               wr_req_q <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_ENTRY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
// Directed bench for ram_loader. Stimulus tasks press keys; every commit that
// should reach memory pushes its expected address/data into a queue, and an
// independent monitor pops and compares whenever wr_req rises. A responder
// process plays the memory and acknowledges after a programmable delay.
module tb_ram_loader;
   import ram_loader_pkg::*;

   localparam int ADDR_W      = 7;
   localparam int DATA_W      = 32;
   localparam int ACK_TIMEOUT = 255;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              sysclk = 1'b0;
   logic              reset;
   logic [3:0]        sw_nibble;
   logic [ADDR_W-1:0] sw_addr;
   logic              key_enter;
   logic              key_commit;
   logic              key_clear;
   logic [DATA_W-1:0] entry_data;
   logic [NIB_W-1:0]  nib_cnt;
   logic              busy;
   logic              done;
   logic              err;

   wr_t  exp_q[$];
   int   checks       = 0;
   int   failures     = 0;
   int   ack_delay    = -1;
   int   req_age      = 0;
   int   write_count  = 0;
   int   last_req_len = 0;
   int   done_cnt     = 0;
   int   done_cyc     = 0;
   int   base_cnt     = 0;
   logic prev_req     = 1'b0;
   logic prev_done    = 1'b0;
   int   req_len      = 0;
   logic req_stable   = 1'b1;
   wr_t  captured;
   wr_t  expected;

   ram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_loader #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .sysclk(sysclk),
      .reset(reset),
      .sw_nibble(sw_nibble),
      .sw_addr(sw_addr),
      .key_enter(key_enter),
      .key_commit(key_commit),
      .key_clear(key_clear),
      .wr(bus.master),
      .entry_data(entry_data),
      .nib_cnt(nib_cnt),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // Free-running 10-unit system clock.
   always #5 sysclk = ~sysclk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic clr, input logic com, input logic ent, input int hold);
      @(negedge sysclk);
      key_clear  = clr;
      key_commit = com;
      key_enter  = ent;
      repeat (hold) @(negedge sysclk);
      key_clear  = 1'b0;
      key_commit = 1'b0;
      key_enter  = 1'b0;
      repeat (5) @(negedge sysclk);
   endtask

   task automatic enterNibble(input logic [3:0] n);
      sw_nibble = n;
      applyStimulus(1'b0, 1'b0, 1'b1, 4);
   endtask

   task automatic waitDone(input string name, input int base, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (done_cnt > base) break;
         @(negedge sysclk);
      end
      checkOutput(name, 64'(done_cnt > base), 64'd1);
   endtask

   task automatic waitErr(input string name, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (err === 1'b1) break;
         @(negedge sysclk);
      end
      checkOutput(name, 64'(err), 64'd1);
   endtask

   // Memory model: raises wr_ack for one cycle once the request has been
   // seen for ack_delay falling edges; a negative delay never acknowledges.
   initial begin
      bus.wr_ack = 1'b0;
      forever begin
         @(negedge sysclk);
         if (bus.wr_req === 1'b1) begin
            bus.wr_ack = (ack_delay >= 0) && (req_age == ack_delay);
            req_age++;
         end else begin
            bus.wr_ack = 1'b0;
            req_age    = 0;
         end
      end
   end

   // Scoreboard monitor: pops the expected write on each new request, checks
   // the bus stays frozen for the whole request, and records its length and
   // the done pulses it sees.
   initial begin
      forever begin
         @(negedge sysclk);
         if (done === 1'b1) done_cyc++;
         if (done === 1'b1 && prev_done !== 1'b1) done_cnt++;
         prev_done = done;
         if (bus.wr_req === 1'b1 && prev_req !== 1'b1) begin
            write_count++;
            req_len    = 1;
            req_stable = 1'b1;
            captured   = '{addr: bus.wr_addr, data: bus.wr_data};
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_write actual=addr 0x%0h data 0x%0h expected=no write",
                        bus.wr_addr, bus.wr_data);
            end else begin
               expected = exp_q.pop_front();
               checkOutput("wr_addr", 64'(bus.wr_addr), 64'(expected.addr));
               checkOutput("wr_data", 64'(bus.wr_data), 64'(expected.data));
            end
         end else if (bus.wr_req === 1'b1) begin
            req_len++;
            if (bus.wr_addr !== captured.addr || bus.wr_data !== captured.data) req_stable = 1'b0;
         end else if (prev_req === 1'b1) begin
            last_req_len = req_len;
            checkOutput("wr_stable", 64'(req_stable), 64'd1);
         end
         prev_req = bus.wr_req;
      end
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=still running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int wc;
      reset      = 1'b1;
      key_enter  = 1'b0;
      key_commit = 1'b0;
      key_clear  = 1'b0;
      sw_nibble  = 4'h0;
      sw_addr    = '0;
      repeat (3) @(negedge sysclk);
      checkOutput("rst_entry", 64'(entry_data), 64'd0);
      checkOutput("rst_nib", 64'(nib_cnt), 64'd0);
      checkOutput("rst_flags", 64'({bus.wr_req, busy, done, err}), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge sysclk);

      $display("[TB] basic write of 12345678 to address 5");
      sw_addr = 7'h05;
      for (int i = 1; i <= 8; i++) enterNibble(4'(i));
      checkOutput("entry_8nib", 64'(entry_data), 64'h12345678);
      checkOutput("nib_8", 64'(nib_cnt), 64'd8);
      exp_q.push_back('{addr: 7'h05, data: 32'h12345678});
      ack_delay = 3;
      base_cnt  = done_cnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      waitDone("done_seen", base_cnt, 50);
      repeat (3) @(negedge sysclk);
      checkOutput("done_once", 64'(done_cnt), 64'd1);
      checkOutput("done_width", 64'(done_cyc), 64'd1);
      checkOutput("req_len_ack3", 64'(last_req_len), 64'd4);
      checkOutput("entry_after_done", 64'(entry_data), 64'd0);
      checkOutput("nib_after_done", 64'(nib_cnt), 64'd0);
      checkOutput("busy_after_done", 64'(busy), 64'd0);

      $display("[TB] ten enters saturate at eight nibbles");
      for (int i = 0; i < 10; i++) enterNibble(4'(i));
      checkOutput("entry_sat", 64'(entry_data), 64'h01234567);
      checkOutput("nib_sat", 64'(nib_cnt), 64'd8);

      $display("[TB] commit with empty entry");
      applyStimulus(1'b1, 1'b0, 1'b0, 4);
      checkOutput("clear_entry", 64'(entry_data), 64'd0);
      checkOutput("clear_nib", 64'(nib_cnt), 64'd0);
      wc = write_count;
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      repeat (5) @(negedge sysclk);
      checkOutput("empty_commit_writes", 64'(write_count), 64'(wc));
      checkOutput("empty_commit_busy", 64'({bus.wr_req, busy}), 64'd0);

      $display("[TB] write with no ack times out");
      sw_addr = 7'h2A;
      enterNibble(4'hA);
      enterNibble(4'hB);
      exp_q.push_back('{addr: 7'h2A, data: 32'h000000AB});
      ack_delay = -1;
      base_cnt  = done_cnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      waitErr("timeout_err", 400);
      repeat (2) @(negedge sysclk);
      checkOutput("req_len_timeout", 64'(last_req_len), 64'(ACK_TIMEOUT));
      checkOutput("entry_kept", 64'(entry_data), 64'h000000AB);
      checkOutput("nib_kept", 64'(nib_cnt), 64'd2);
      checkOutput("timeout_no_done", 64'(done_cnt), 64'(base_cnt));
      checkOutput("timeout_idle", 64'({bus.wr_req, busy}), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4);
      checkOutput("clear_err", 64'(err), 64'd0);
      checkOutput("clear_entry2", 64'(entry_data), 64'd0);

      $display("[TB] ack on the last allowed cycle");
      sw_addr = 7'h11;
      enterNibble(4'hC);
      exp_q.push_back('{addr: 7'h11, data: 32'h0000000C});
      ack_delay = ACK_TIMEOUT - 1;
      base_cnt  = done_cnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      waitDone("late_ack_done", base_cnt, 400);
      repeat (3) @(negedge sysclk);
      checkOutput("late_ack_err", 64'(err), 64'd0);
      checkOutput("req_len_late", 64'(last_req_len), 64'(ACK_TIMEOUT));
      checkOutput("late_ack_entry", 64'(entry_data), 64'd0);

      $display("[TB] clear, commit and enter together");
      enterNibble(4'h3);
      checkOutput("pre_prio_entry", 64'(entry_data), 64'h3);
      wc        = write_count;
      ack_delay = 3;
      sw_nibble = 4'hF;
      applyStimulus(1'b1, 1'b1, 1'b1, 4);
      repeat (5) @(negedge sysclk);
      checkOutput("prio_entry", 64'(entry_data), 64'd0);
      checkOutput("prio_nib", 64'(nib_cnt), 64'd0);
      checkOutput("prio_writes", 64'(write_count), 64'(wc));

      $display("[TB] enter held for 100 cycles");
      sw_nibble = 4'h7;
      applyStimulus(1'b0, 1'b0, 1'b1, 100);
      checkOutput("held_entry", 64'(entry_data), 64'h7);
      checkOutput("held_nib", 64'(nib_cnt), 64'd1);

      $display("[TB] reset during a write");
      sw_addr = 7'h03;
      exp_q.push_back('{addr: 7'h03, data: 32'h00000007});
      ack_delay = -1;
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      checkOutput("busy_in_write", 64'({bus.wr_req, busy}), 64'd3);
      @(negedge sysclk);
      #1 reset = 1'b1;
      #1;
      checkOutput("async_rst_flags", 64'({bus.wr_req, busy, done, err}), 64'd0);
      checkOutput("async_rst_entry", 64'({entry_data, nib_cnt}), 64'd0);
      @(negedge sysclk);
      reset = 1'b0;
      repeat (3) @(negedge sysclk);
      checkOutput("post_rst_idle", 64'({bus.wr_req, busy}), 64'd0);
      enterNibble(4'h9);
      checkOutput("post_rst_entry", 64'(entry_data), 64'h9);
      checkOutput("post_rst_nib", 64'(nib_cnt), 64'd1);

      repeat (5) @(negedge sysclk);
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
